// File: rtl/mux_n_pipe_pkg.sv
// Shared types and helpers for the N-input pipelined selector.
package mux_n_pipe_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefNumIn = 4;

    // Occupancy of the main/skid register pair.
    typedef enum logic [1:0] {
        StEmpty,  // nothing buffered, out_valid low
        StOne,    // main holds a word
        StTwo     // main and skid both hold words, inputs blocked
    } occ_e;

    // Select width for n inputs: ceil(log2(n)), never below 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 word selector; out-of-range select yields zero.
module mux_n #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]        out_data
);

    // Scan all channels; only a matching index drives the result.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input selector with registered output and valid/ready on every port.
// A main register drives the output and a skid register absorbs one word
// while the consumer stalls, so in_ready never depends on out_ready.
module mux_n_pipe
    import mux_n_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned NUM_IN = DefNumIn,
    parameter int unsigned SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] sel_data;
    logic             can_accept;
    logic             in_xfer;
    logic             out_xfer;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel      (sel),
        .in_data  (in_data),
        .out_data (sel_data)
    );

    assign sel_err    = (32'(sel) >= NUM_IN);
    assign can_accept = (state_q != StTwo) && !sel_err;

    // Ready is one-hot on the selected channel, derived from state and sel only.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_ready[k] = (sel == SEL_W'(k)) && can_accept;
        end
    end

    assign in_xfer   = |(in_valid & in_ready);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign out_xfer  = out_valid && out_ready;

    // Next-state: load main, spill into skid on stall, refill main from skid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    main_d  = sel_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (out_xfer) begin
                    if (in_xfer) begin
                        main_d = sel_data;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (in_xfer) begin
                    skid_d  = sel_data;
                    state_d = StTwo;
                end
            end
            StTwo: begin
                // Inputs are blocked here, so only the drain path exists.
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Storage registers; reset discards anything buffered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and queue-model checks for mux_n_pipe.
module tb_mux_n_pipe;

    logic         clock;
    logic         reset;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         sel_err;

    logic [1:0]   sel3;
    logic [23:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [7:0]   out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic         sel_err3;

    int n_checks;
    int n_pass;
    logic [31:0] model_q[$];

    mux_n_pipe #(
        .WIDTH  (32),
        .NUM_IN (4),
        .SEL_W  (2)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    mux_n_pipe #(
        .WIDTH  (8),
        .NUM_IN (3),
        .SEL_W  (2)
    ) u_dut3 (
        .clock     (clock),
        .reset     (reset),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare against the queue model for the current inputs, then advance the model.
    task automatic model_cycle();
        logic [3:0] exp_ready;
        #1;
        exp_ready = (model_q.size() < 2) ? (4'b0001 << sel) : 4'b0000;
        check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
        check("rnd_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("rnd_out_data", out_data, model_q[0]);
            if (out_ready) begin
                void'(model_q.pop_front());
            end
        end
        if ((in_valid & exp_ready) != 4'b0000) begin
            model_q.push_back(in_data[sel*32 +: 32]);
        end
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        sel        = 2'd0;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = 1'b1;
        sel3       = 2'd0;
        in_data3   = '0;
        in_valid3  = '0;
        out_ready3 = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        tick();

        // Streaming on channel 2
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data[64 +: 32] = 32'h11;
        #1;
        check("str_in_ready", 32'(in_ready), 32'h4);
        check("str_idle", 32'(out_valid), 32'd0);
        tick();
        check("str_v0", 32'(out_valid), 32'd1);
        check("str_d0", out_data, 32'h11);
        in_data[64 +: 32] = 32'h22;
        tick();
        check("str_d1", out_data, 32'h22);
        in_data[64 +: 32] = 32'h33;
        tick();
        check("str_d2", out_data, 32'h33);
        check("str_v2", 32'(out_valid), 32'd1);
        in_valid = 4'b0000;
        tick();
        check("str_done", 32'(out_valid), 32'd0);
        check("str_hold", out_data, 32'h33);

        // Stall into the skid register
        in_valid = 4'b0100;
        in_data[64 +: 32] = 32'hA1;
        tick();
        check("stl_a1", out_data, 32'hA1);
        out_ready = 1'b0;
        in_data[64 +: 32] = 32'hA2;
        #1;
        check("stl_rdy_open", 32'(in_ready), 32'h4);
        tick();
        check("stl_rdy_blk", 32'(in_ready), 32'h0);
        check("stl_hold_a1", out_data, 32'hA1);
        in_valid = 4'b0000;
        tick();
        check("stl_still_a1", out_data, 32'hA1);
        check("stl_still_v", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("stl_a2", out_data, 32'hA2);
        check("stl_a2_v", 32'(out_valid), 32'd1);
        check("stl_rdy_back", 32'(in_ready), 32'h4);
        tick();
        check("stl_empty", 32'(out_valid), 32'd0);

        // Channel switching 0,3,0
        in_data[0 +: 32]  = 32'hC0;
        in_data[96 +: 32] = 32'hC3;
        in_valid = 4'b1001;
        sel      = 2'd0;
        #1;
        check("sw_rdy0", 32'(in_ready), 32'h1);
        tick();
        check("sw_c0", out_data, 32'hC0);
        sel = 2'd3;
        #1;
        check("sw_rdy3", 32'(in_ready), 32'h8);
        tick();
        check("sw_c3", out_data, 32'hC3);
        sel = 2'd0;
        #1;
        check("sw_rdy0b", 32'(in_ready), 32'h1);
        tick();
        check("sw_c0b", out_data, 32'hC0);
        in_valid = 4'b0000;
        tick();
        check("sw_empty", 32'(out_valid), 32'd0);

        // Reset with skid full
        out_ready = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        in_data[32 +: 32] = 32'h55;
        tick();
        in_data[32 +: 32] = 32'h66;
        tick();
        check("mr_full", 32'(in_ready), 32'h0);
        check("mr_main", out_data, 32'h55);
        reset = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data", out_data, 32'd0);
        check("mr_rdy_sel1", 32'(in_ready), 32'h2);
        in_valid = 4'b0000;
        sel      = 2'd0;
        #1;
        reset = 1'b0;
        #1;
        check("mr_rdy_sel0", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        tick();
        check("mr_no_output", 32'(out_valid), 32'd0);

        // Out-of-range select on the 3-input instance
        in_data3   = {8'h32, 8'h31, 8'h30};
        in_valid3  = 3'b111;
        sel3       = 2'd0;
        #1;
        check("oor_rdy0", 32'(in_ready3), 32'h1);
        check("oor_err0", 32'(sel_err3), 32'd0);
        tick();
        check("oor_d30", 32'(out_data3), 32'h30);
        sel3 = 2'd3;
        #1;
        check("oor_err", 32'(sel_err3), 32'd1);
        check("oor_rdy_none", 32'(in_ready3), 32'h0);
        tick();
        check("oor_held_v", 32'(out_valid3), 32'd1);
        check("oor_held_d", 32'(out_data3), 32'h30);
        out_ready3 = 1'b1;
        tick();
        check("oor_drained", 32'(out_valid3), 32'd0);
        check("oor_hold_d", 32'(out_data3), 32'h30);
        sel3 = 2'd2;
        #1;
        check("oor_err_clr", 32'(sel_err3), 32'd0);
        check("oor_rdy2", 32'(in_ready3), 32'h4);
        tick();
        check("oor_d32", 32'(out_data3), 32'h32);
        in_valid3 = 3'b000;
        tick();

        // Random traffic against a FIFO model
        model_q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                in_data[k*32 +: 32] = $urandom;
            end
            model_cycle();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            model_cycle();
        end
        check("rnd_model_empty", 32'(model_q.size()), 32'd0);
        check("rnd_dut_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
